upcounter_stopwatch: RTL and testbench
======================================

// Module: upcounter_stopwatch
// PURPOSE
//   Count-up mm:ss stopwatch core; counterpart to the 2-digit down-counting timer.
//   Holds four BCD digits (00:00..59:59) and advances one second per tick pulse.
//   Start/pause, lap-freeze and clear are controlled by a 4-state FSM.
//   Digits feed scan_ctl/display unchanged; all pulse inputs arrive debounced, one-pulsed.
// PARAMETERS
//   STOP_AT_MAX  0  0: 59:59 wraps to 00:00; 1: saturate at 59:59 and force PAUSE
// PORTS
//   clk          in   1  system clock; all state changes on rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   tick         in   1  1-cycle pulse, one per second (clk domain, from freq divider)
//   start_pause  in   1  1-cycle pulse: toggle run/pause
//   lap          in   1  1-cycle pulse: freeze/unfreeze displayed value
//   clear        in   1  1-cycle pulse: zero count, return to IDLE
//   disp_m1      out  4  displayed minutes tens   (BCD 0..5)
//   disp_m0      out  4  displayed minutes units  (BCD 0..9)
//   disp_s1      out  4  displayed seconds tens   (BCD 0..5)
//   disp_s0      out  4  displayed seconds units  (BCD 0..9)
//   running      out  1  high in RUN or LAP
//   lap_active   out  1  high in LAP
//   is_zero      out  1  high when live count == 00:00
//   rollover     out  1  1-cycle pulse when tick arrives at 59:59
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, live count=00:00, lap regs=00:00,
//     rollover=0; hence disp_*=0, running=0, lap_active=0, is_zero=1.
//   States: IDLE, RUN, PAUSE, LAP (count continues, display frozen).
//   Input priority, same cycle: clear > start_pause > lap.
//   Transitions: any --clear--> IDLE (live and lap regs zeroed);
//     IDLE --start--> RUN;  RUN --start--> PAUSE;  RUN --lap--> LAP;
//     LAP --lap--> RUN;     LAP --start--> PAUSE;  PAUSE --start--> RUN;
//     lap ignored in IDLE/PAUSE; no other transitions.
//   Increment: on an edge with tick=1, current state in {RUN, LAP}, and clear=0.
//     Current state decides, so RUN+start+tick increments then enters PAUSE;
//     PAUSE+start+tick does not increment.
//   BCD carry: s0 9->0 carries s1; s1 5->0 carries m0; m0 9->0 carries m1;
//     m1 5->0 at 59:59 is handled by STOP_AT_MAX. Digits never leave BCD range.
//   59:59 + tick: rollover=1 for exactly the next cycle.
//     STOP_AT_MAX=0: count -> 00:00, state unchanged.
//     STOP_AT_MAX=1: count holds 59:59, state -> PAUSE, lap_active clears.
//   Lap latch: on RUN->LAP, lap regs capture the pre-edge live count,
//     even if tick is high the same cycle.
//   Display: lap regs when state==LAP, live count otherwise (combinational mux).
//     A tick is visible on disp_* in the cycle after its edge.
//   running, lap_active, is_zero: combinational from registered state/count.
//   Reset mid-count: immediate return to reset values; no partial digit update.
// TESTING
//   1 Reset, start, 5 ticks -> disp=00:05, running=1, is_zero=0.
//   2 Preload via 599 ticks in RUN -> 09:59; 1 more tick -> 10:00.
//     3599 ticks -> 59:59; next tick (STOP_AT_MAX=0) -> 00:00, rollover 1 cycle.
//   3 RUN at 00:10; lap+tick same cycle -> disp holds 00:10, lap_active=1;
//     3 ticks later disp still 00:10; lap -> disp=00:14.
//   4 RUN at 00:03; start+tick same cycle -> 00:04 and PAUSE;
//     2 ticks -> still 00:04; start -> RUN.
//   5 clear+start+tick in RUN at 01:23 -> IDLE, 00:00, is_zero=1, running=0.
//   6 STOP_AT_MAX=1 at 59:59 in LAP; tick -> 59:59 held, PAUSE, rollover=1;
//     rst_n pulse mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/upcounter_stopwatch.sv
// Count-up mm:ss stopwatch core: four BCD digits (00:00..59:59) advanced by a
// one-second tick, with run/pause, lap-freeze and clear handled by a 4-state FSM.
module upcounter_stopwatch #(
  parameter bit STOP_AT_MAX = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_m0,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_s0,
  output logic       running,
  output logic       lap_active,
  output logic       is_zero,
  output logic       rollover
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_m1, r_m0, r_s1, r_s0;
  logic [3:0] r_lap_m1, r_lap_m0, r_lap_s1, r_lap_s0;
  logic       r_rollover;
  logic [3:0] w_m1_nxt, w_m0_nxt, w_s1_nxt, w_s0_nxt;
  logic       w_lap_capture, w_rollover_nxt, w_inc, w_at_max;

  // The state before the edge decides whether a tick counts.
  assign w_inc    = tick && !clear && ((r_state == S_RUN) || (r_state == S_LAP));
  assign w_at_max = (r_m1 == 4'd5) && (r_m0 == 4'd9) && (r_s1 == 4'd5) && (r_s0 == 4'd9);

  always_comb begin
    w_state_nxt    = r_state;
    w_m1_nxt       = r_m1;
    w_m0_nxt       = r_m0;
    w_s1_nxt       = r_s1;
    w_s0_nxt       = r_s0;
    w_lap_capture  = 1'b0;
    w_rollover_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_m1_nxt    = 4'd0;
      w_m0_nxt    = 4'd0;
      w_s1_nxt    = 4'd0;
      w_s0_nxt    = 4'd0;
    end else begin
      case (r_state)
        S_IDLE:  if (start_pause) w_state_nxt = S_RUN;
        S_RUN: begin
          if (start_pause) begin
            w_state_nxt = S_PAUSE;
          end else if (lap) begin
            w_state_nxt   = S_LAP;
            w_lap_capture = 1'b1;
          end
        end
        S_LAP: begin
          if (start_pause)  w_state_nxt = S_PAUSE;
          else if (lap)     w_state_nxt = S_RUN;
        end
        S_PAUSE: if (start_pause) w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_inc) begin
        if (w_at_max) begin
          w_rollover_nxt = 1'b1;
          if (STOP_AT_MAX) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_m1_nxt = 4'd0;
            w_m0_nxt = 4'd0;
            w_s1_nxt = 4'd0;
            w_s0_nxt = 4'd0;
          end
        end else if (r_s0 != 4'd9) begin
          w_s0_nxt = r_s0 + 4'd1;
        end else begin
          w_s0_nxt = 4'd0;
          if (r_s1 != 4'd5) begin
            w_s1_nxt = r_s1 + 4'd1;
          end else begin
            w_s1_nxt = 4'd0;
            if (r_m0 != 4'd9) begin
              w_m0_nxt = r_m0 + 4'd1;
            end else begin
              w_m0_nxt = 4'd0;
              w_m1_nxt = r_m1 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m1       <= 4'd0;
      r_m0       <= 4'd0;
      r_s1       <= 4'd0;
      r_s0       <= 4'd0;
      r_rollover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_m1       <= w_m1_nxt;
      r_m0       <= w_m0_nxt;
      r_s1       <= w_s1_nxt;
      r_s0       <= w_s0_nxt;
      r_rollover <= w_rollover_nxt;
    end
  end

  // Lap registers latch the pre-edge live count, ignoring a same-cycle tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_m1 <= 4'd0;
      r_lap_m0 <= 4'd0;
      r_lap_s1 <= 4'd0;
      r_lap_s0 <= 4'd0;
    end else if (clear) begin
      r_lap_m1 <= 4'd0;
      r_lap_m0 <= 4'd0;
      r_lap_s1 <= 4'd0;
      r_lap_s0 <= 4'd0;
    end else if (w_lap_capture) begin
      r_lap_m1 <= r_m1;
      r_lap_m0 <= r_m0;
      r_lap_s1 <= r_s1;
      r_lap_s0 <= r_s0;
    end
  end

  assign disp_m1    = (r_state == S_LAP) ? r_lap_m1 : r_m1;
  assign disp_m0    = (r_state == S_LAP) ? r_lap_m0 : r_m0;
  assign disp_s1    = (r_state == S_LAP) ? r_lap_s1 : r_s1;
  assign disp_s0    = (r_state == S_LAP) ? r_lap_s0 : r_s0;
  assign running    = (r_state == S_RUN) || (r_state == S_LAP);
  assign lap_active = (r_state == S_LAP);
  assign is_zero    = (r_m1 == 4'd0) && (r_m0 == 4'd0) && (r_s1 == 4'd0) && (r_s0 == 4'd0);
  assign rollover   = r_rollover;

endmodule

// File: tb/tb_upcounter_stopwatch.sv
// Scoreboard bench for upcounter_stopwatch: wrap (dut0) and saturate (dut1)
// variants driven in parallel against a seconds-count reference model.
module tb_upcounter_stopwatch;

  logic clk, rst_n, tick, start_pause, lap, clear;
  logic [3:0] d0_m1, d0_m0, d0_s1, d0_s0, d1_m1, d1_m0, d1_s1, d1_s0;
  logic d0_run, d0_lapa, d0_zero, d0_roll, d1_run, d1_lapa, d1_zero, d1_roll;

  upcounter_stopwatch #(.STOP_AT_MAX(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_pause(start_pause), .lap(lap), .clear(clear),
    .disp_m1(d0_m1), .disp_m0(d0_m0), .disp_s1(d0_s1), .disp_s0(d0_s0),
    .running(d0_run), .lap_active(d0_lapa), .is_zero(d0_zero), .rollover(d0_roll));

  upcounter_stopwatch #(.STOP_AT_MAX(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_pause(start_pause), .lap(lap), .clear(clear),
    .disp_m1(d1_m1), .disp_m0(d1_m0), .disp_s1(d1_s1), .disp_s0(d1_s0),
    .running(d1_run), .lap_active(d1_lapa), .is_zero(d1_zero), .rollover(d1_roll));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: live count and lap value kept as plain seconds 0..3599.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int m_state [2];
  int m_cnt   [2];
  int m_lap   [2];
  bit m_roll  [2];

  logic [19:0] q0[$], q1[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [19:0] exp_vec(input int k);
    int v;
    logic [3:0] m1, m0, s1, s0;
    v  = (m_state[k] == M_LAP) ? m_lap[k] : m_cnt[k];
    m1 = 4'(v / 600);
    m0 = 4'((v / 60) % 10);
    s1 = 4'((v % 60) / 10);
    s0 = 4'(v % 10);
    return {m1, m0, s1, s0,
            (m_state[k] == M_RUN) || (m_state[k] == M_LAP),
            m_state[k] == M_LAP, m_cnt[k] == 0, m_roll[k]};
  endfunction

  task automatic model_reset(input int k);
    m_state[k] = M_IDLE;
    m_cnt[k]   = 0;
    m_lap[k]   = 0;
    m_roll[k]  = 1'b0;
  endtask

  task automatic model_step(input int k, input logic t, s, l, c);
    int  ns;
    bit  inc;
    if (c) begin
      model_reset(k);
      return;
    end
    inc = t && ((m_state[k] == M_RUN) || (m_state[k] == M_LAP));
    ns  = m_state[k];
    if (s) begin
      ns = (m_state[k] == M_IDLE || m_state[k] == M_PAUSE) ? M_RUN : M_PAUSE;
    end else if (l) begin
      if (m_state[k] == M_RUN) begin
        ns       = M_LAP;
        m_lap[k] = m_cnt[k];
      end else if (m_state[k] == M_LAP) begin
        ns = M_RUN;
      end
    end
    m_roll[k] = inc && (m_cnt[k] == 3599);
    if (inc) begin
      if (m_cnt[k] < 3599)  m_cnt[k] = m_cnt[k] + 1;
      else if (k == 1)      ns = M_PAUSE;
      else                  m_cnt[k] = 0;
    end
    m_state[k] = ns;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got m1m0s1s0=%h run=%b lap=%b zero=%b roll=%b, expected m1m0s1s0=%h run=%b lap=%b zero=%b roll=%b",
               name, $time, act[19:4], act[3], act[2], act[1], act[0],
               exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  logic [19:0] e0, e1;
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("dut0_wrap", {d0_m1, d0_m0, d0_s1, d0_s0, d0_run, d0_lapa, d0_zero, d0_roll}, e0);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("dut1_sat", {d1_m1, d1_m0, d1_s1, d1_s0, d1_run, d1_lapa, d1_zero, d1_roll}, e1);
    end
  end

  task automatic cycle(input logic t, s, l, c, rn);
    @(negedge clk);
    tick = t; start_pause = s; lap = l; clear = c; rst_n = rn;
    for (int k = 0; k < 2; k++) begin
      if (!rn) model_reset(k);
      else     model_step(k, t, s, l, c);
    end
    q0.push_back(exp_vec(0));
    q1.push_back(exp_vec(1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic restart;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Drop rst_n between edges and confirm both copies clear without a clock.
  task automatic async_reset;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check("async_rst0", {d0_m1, d0_m0, d0_s1, d0_s0, d0_run, d0_lapa, d0_zero, d0_roll}, exp_vec(0));
    check("async_rst1", {d1_m1, d1_m0, d1_s1, d1_s0, d1_run, d1_lapa, d1_zero, d1_roll}, exp_vec(1));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_pause = 1'b0; lap = 1'b0; clear = 1'b0;
    model_reset(0);
    model_reset(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Start and five ticks
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(5);
    // Minute carry, then full range up to 59:59 and past it
    restart;
    ticks(599);
    ticks(1);
    ticks(2999);
    ticks(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Lap freeze with same-cycle tick
    restart;
    ticks(10);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // Pause with same-cycle tick; ticks ignored while paused
    restart;
    ticks(3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(2);
    // Clear wins over start and tick
    restart;
    ticks(83);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // 59:59 reached while in LAP
    restart;
    ticks(3599);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(4);
    async_reset;
    // Randomized traffic with occasional async reset
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 4999) == 0) begin
        async_reset;
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 2999) == 0, 1'b1);
      end
    end
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
